// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct3 ops and FSM states.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_step.sv
// One (W+1)-bit add/subtract with carry out; shared by the multiply add and the divide trial subtract.
module md_step #(
  parameter int W = 64
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  input  logic       sub,
  output logic [W:0] sum,
  output logic       cout
);

  logic [W+1:0] full;

  // In subtract mode cout=1 means a >= b (no borrow).
  assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(W+1){1'b0}}, sub};
  assign sum  = full[W:0];
  assign cout = full[W+1];

endmodule

// File: rtl/iter_mul_div.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide, one step per cycle.
module iter_mul_div
  import md_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [WORDSIZE-1:0] operand_a,
  input  logic [WORDSIZE-1:0] operand_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] result
);

  localparam int W  = WORDSIZE;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_e         state;
  logic [2:0]     op_q;
  logic           neg_res;
  logic [W-1:0]   hi, lo, mcand;
  logic [CW-1:0]  cnt;

  logic           signed_a, signed_b, neg_a, neg_b, div_zero, div_ovf;
  logic [W-1:0]   mag_a, mag_b, fast_res;
  logic           div_mode;
  logic [W:0]     step_a, step_b, step_sum;
  logic           step_cout;
  logic signed [2*W-1:0] fix_in, fix_val;
  logic [W-1:0]   fix_res;

  // Accept-side decode: operand magnitudes, result sign, divide special cases.
  assign signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign neg_a    = signed_a && operand_a[W-1];
  assign neg_b    = signed_b && operand_b[W-1];
  assign mag_a    = neg_a ? (~operand_a + 1'b1) : operand_a;
  assign mag_b    = neg_b ? (~operand_b + 1'b1) : operand_b;
  assign div_zero = is_div(op) && (operand_b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (operand_a == MIN_NEG) && (operand_b == '1);
  assign fast_res = div_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : MIN_NEG);

  // Iteration step: multiply adds mcand into hi when the multiplier LSB is set;
  // divide subtracts the divisor from the shifted partial remainder.
  assign div_mode = is_div(op_q);
  assign step_a   = div_mode ? {hi, lo[W-1]} : {1'b0, hi};
  assign step_b   = {1'b0, (div_mode || lo[0]) ? mcand : '0};

  md_step #(.W(W)) u_step (
    .a    (step_a),
    .b    (step_b),
    .sub  (div_mode),
    .sum  (step_sum),
    .cout (step_cout)
  );

  // Fix-up: one 2W-bit negator covers the product and the quotient/remainder.
  assign fix_in  = div_mode ? {{W{1'b0}}, (op_q[1] ? hi : lo)} : {hi, lo};
  assign fix_val = neg_res ? -fix_in : fix_in;
  assign fix_res = (div_mode || (op_q == OP_MUL)) ? fix_val[W-1:0] : fix_val[2*W-1:W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      op_q      <= '0;
      neg_res   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            neg_res  <= (op == OP_REM) ? neg_a : (neg_a ^ neg_b);
            hi       <= '0;
            lo       <= is_div(op) ? mag_a : mag_b;
            mcand    <= is_div(op) ? mag_b : mag_a;
            cnt      <= CW'(W - 1);
            in_ready <= 1'b0;
            if (div_zero || div_ovf) begin
              result    <= fast_res;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (div_mode) begin
            hi <= step_cout ? step_sum[W-1:0] : step_a[W-1:0];
            lo <= {lo[W-2:0], step_cout};
          end else begin
            hi <= step_sum[W:1];
            lo <= {step_sum[0], lo[W-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= ST_FIX;
        end
        ST_FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mul_div.sv
// Randomized scoreboard bench for iter_mul_div at WORDSIZE=8, plus directed WORDSIZE=64 cases.
module tb_iter_mul_div;

  typedef struct {
    logic [7:0] res;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [7:0] operand_a, operand_b, result;

  logic        rst64_n, iv64, ir64, ov64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, res64;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   stall_req = 0;
  int   stall_cnt = 0;
  logic prev_ov = 1'b0;
  logic hs = 1'b0;
  logic [7:0] held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_mul_div #(.WORDSIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  iter_mul_div #(.WORDSIZE(64)) dut64 (
    .clk(clk), .rst_n(rst64_n), .flush(1'b0), .in_valid(iv64), .in_ready(ir64),
    .op(op64), .operand_a(a64), .operand_b(b64), .out_valid(ov64),
    .out_ready(1'b1), .result(res64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the RISC-V M-extension definitions.
  function automatic logic [7:0] ref_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, ua, ub, p;
    sa = int'($signed(a)); sb = int'($signed(b));
    ua = int'(a);          ub = int'(b);
    case (o)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >>> 8;
      3'd2: p = (sa * ub) >>> 8;
      3'd3: p = (ua * ub) >>> 8;
      3'd4: p = (ub == 0) ? -1 : ((a == 8'h80 && b == 8'hFF) ? 128 : sa / sb);
      3'd5: p = (ub == 0) ? 255 : ua / ub;
      3'd6: p = (ub == 0) ? ua : ((a == 8'h80 && b == 8'hFF) ? 0 : sa % sb);
      default: p = (ub == 0) ? ua : ua % ub;
    endcase
    return p[7:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    if (o >= 3'd4 && b == 8'h00) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 8'h80 && b == 8'hFF) return 1;
    return 10;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input bit push);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("wait_in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk);
    #1;
    if (push) begin
      e.res  = ref_res(o, a, b);
      e.lat  = ref_lat(o, a, b);
      e.acc  = cyc;
      e.name = $sformatf("op%0d_a%02h_b%02h", o, a, b);
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || !in_ready) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: drives out_ready, checks latency, stability under backpressure and results.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (!prev_ov) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk({sb[0].name, "_latency"}, 64'(cyc + 1 - sb[0].acc), 64'(sb[0].lat));
          held = result;
          if (stall_req > 0) begin
            stall_cnt = stall_req;
            stall_req = 0;
          end
        end
      end else begin
        chk("result_stable", 64'(result), 64'(held));
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
        chk("in_ready_while_done", 64'(in_ready), 64'd0);
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk(e.name, 64'(result), 64'(e.res));
        end
        hs = 1'b1;
      end
    end else begin
      if (hs) chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
      hs = 1'b0;
      out_ready = $urandom_range(0, 1);
    end
    prev_ov = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] o;
    logic [7:0] a, b;
    int         n, k;
    rst_n = 1'b0; rst64_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    op = '0; operand_a = '0; operand_b = '0; out_ready = 1'b0;
    iv64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1; rst64_n = 1'b1;

    issue(3'd2, 8'hFF, 8'hFF, 1'b1);
    issue(3'd4, 8'hF9, 8'h02, 1'b1);
    issue(3'd6, 8'hF9, 8'h02, 1'b1);
    issue(3'd7, 8'hF9, 8'h02, 1'b1);
    issue(3'd5, 8'h35, 8'h00, 1'b1);
    issue(3'd6, 8'h80, 8'hFF, 1'b1);
    issue(3'd4, 8'h80, 8'hFF, 1'b1);
    drain();

    stall_req = 5;
    issue(3'd0, 8'h0D, 8'h0B, 1'b1);
    drain();

    // Flush in the middle of CALC with a competing request.
    issue(3'd0, 8'h55, 8'h33, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd5; operand_a = 8'h40; operand_b = 8'h03;
    @(posedge clk);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    repeat (15) @(negedge clk);
    issue(3'd0, 8'h07, 8'h06, 1'b1);
    drain();

    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 7))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = 8'hFF;
        default: ;
      endcase
      issue(o, a, b, 1'b1);
    end
    drain();

    // Wide instance: full-scale MULHU and reset mid-operation.
    @(negedge clk);
    iv64 = 1'b1; op64 = 3'd3; a64 = '1; b64 = '1;
    @(posedge clk);
    #1;
    n = cyc;
    @(negedge clk);
    iv64 = 1'b0;
    k = 0;
    while (!ov64 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("w64_mulhu_latency", 64'(cyc + 1 - n), 64'd66);
    chk("w64_mulhu_result", res64, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (2) @(negedge clk);
    iv64 = 1'b1; op64 = 3'd0; a64 = 64'h1234; b64 = 64'h5678;
    @(posedge clk);
    @(negedge clk);
    iv64 = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    rst64_n = 1'b0;
    @(posedge clk);
    #1;
    chk("w64_reset_out_valid", 64'(ov64), 64'd0);
    chk("w64_reset_result", res64, 64'd0);
    chk("w64_reset_in_ready", 64'(ir64), 64'd1);
    @(negedge clk);
    rst64_n = 1'b1;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
